// File: rtl/alu_pkg.sv
// Shared command encodings, status-register bit positions and FSM states
// for the handshaked EXE-stage ALU.
package alu_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  localparam int SR_Z = 3;
  localparam int SR_C = 2;
  localparam int SR_N = 1;
  localparam int SR_V = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DONE     = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Command/result handshake bundle between the ID/EXE register and the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_cmd;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic             c_in;
  logic             v_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       sr;

  modport master (
    output in_valid, alu_cmd, val1, val2, c_in, v_in, out_ready,
    input  in_ready, out_valid, alu_out, sr
  );

  modport slave (
    input  in_valid, alu_cmd, val1, val2, c_in, v_in, out_ready,
    output in_ready, out_valid, alu_out, sr
  );
endinterface

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per clock, exactly WIDTH
// iterations. done is raised during the final iteration with product valid.
module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  logic [WIDTH-1:0] mcand_reg, mplier_reg, acc_reg, acc_next;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;

  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  // Handing out acc_next lets the caller capture the result on the last iteration edge.
  assign done     = busy_reg & (cnt_reg == CNT_LAST);
  assign product  = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= a;
      mplier_reg <= b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      if (cnt_reg != CNT_FULL) cnt_reg <= cnt_reg + 1'b1;
      if (done) busy_reg <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Handshaked EXE-stage ALU: single-cycle command set plus optional iterative
// MUL, with registered result and {Z,C,N,V} status. One operation in flight.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.slave  bus
);
  state_t           state_reg, state_next;
  logic [WIDTH-1:0] alu_out_reg, alu_out_next;
  logic [3:0]       sr_reg, sr_next;
  logic             c_hold_reg, v_hold_reg;
  logic             accept, is_mul, mul_start, mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] b_eff, res;
  logic [WIDTH:0]   sum;
  logic             cin, c_flag, v_flag;

  function automatic logic [3:0] pack_sr(input logic [WIDTH-1:0] r, input logic c, input logic v);
    logic [3:0] s;
    s       = '0;
    s[SR_Z] = (r == '0);
    s[SR_C] = c;
    s[SR_N] = r[WIDTH-1];
    s[SR_V] = v;
    return s;
  endfunction

  assign bus.in_ready  = (state_reg == IDLE) | ((state_reg == DONE) & bus.out_ready);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.alu_out   = alu_out_reg;
  assign bus.sr        = sr_reg;
  assign accept        = bus.in_valid & bus.in_ready;
  assign is_mul        = MUL_EN && (bus.alu_cmd == CMD_MUL);

  // Subtraction shares the adder as val1 + ~val2 + cin, so C is NOT borrow.
  always_comb begin
    b_eff  = bus.val2;
    cin    = 1'b0;
    case (bus.alu_cmd)
      CMD_ADC: cin = bus.c_in;
      CMD_SUB: begin b_eff = ~bus.val2; cin = 1'b1;     end
      CMD_SBC: begin b_eff = ~bus.val2; cin = bus.c_in; end
      default: ;
    endcase
    sum    = {1'b0, bus.val1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    res    = '0;
    c_flag = bus.c_in;
    v_flag = bus.v_in;
    case (bus.alu_cmd)
      CMD_MOV: res = bus.val2;
      CMD_MVN: res = ~bus.val2;
      CMD_ADD, CMD_ADC: begin
        res    = sum[WIDTH-1:0];
        c_flag = sum[WIDTH];
        v_flag = ~(bus.val1[WIDTH-1] ^ bus.val2[WIDTH-1]) & (sum[WIDTH-1] ^ bus.val1[WIDTH-1]);
      end
      CMD_SUB, CMD_SBC: begin
        res    = sum[WIDTH-1:0];
        c_flag = sum[WIDTH];
        v_flag = (bus.val1[WIDTH-1] ^ bus.val2[WIDTH-1]) & (sum[WIDTH-1] ^ bus.val1[WIDTH-1]);
      end
      CMD_AND: res = bus.val1 & bus.val2;
      CMD_ORR: res = bus.val1 | bus.val2;
      CMD_EOR: res = bus.val1 ^ bus.val2;
      default: res = '0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    alu_out_next = alu_out_reg;
    sr_next      = sr_reg;
    mul_start    = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (accept) begin
          if (is_mul) begin
            state_next = MUL_BUSY;
            mul_start  = 1'b1;
          end else begin
            state_next   = DONE;
            alu_out_next = res;
            sr_next      = pack_sr(res, c_flag, v_flag);
          end
        end else if ((state_reg == DONE) && bus.out_ready) begin
          state_next = IDLE;
        end
      end
      MUL_BUSY: begin
        if (mul_done) begin
          state_next   = DONE;
          alu_out_next = mul_product;
          sr_next      = pack_sr(mul_product, c_hold_reg, v_hold_reg);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      alu_out_reg <= '0;
      sr_reg      <= 4'b0000;
      c_hold_reg  <= 1'b0;
      v_hold_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      alu_out_reg <= alu_out_next;
      sr_reg      <= sr_next;
      // MUL preserves the flags seen at acceptance, not those present at completion.
      if (mul_start) begin
        c_hold_reg <= bus.c_in;
        v_hold_reg <= bus.v_in;
      end
    end
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.val1),
        .b       (bus.val2),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=32, MUL_EN=1): inputs driven and
// outputs sampled on the falling edge; expectations queued at drive time.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [31:0] out;
    logic [3:0]  sr;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic        v;
    logic [31:0] out;
    logic [3:0]  sr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic exp_t model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic v);
    exp_t e;
    logic [32:0] s;
    logic [31:0] r;
    logic cf, vf;
    r = '0; cf = c; vf = v; s = '0;
    case (cmd)
      CMD_MOV: r = b;
      CMD_MVN: r = ~b;
      CMD_ADD, CMD_ADC: begin
        s  = {1'b0, a} + {1'b0, b} + 33'((cmd == CMD_ADC) && c);
        r  = s[31:0];
        cf = s[32];
        vf = (a[31] == b[31]) && (r[31] != a[31]);
      end
      CMD_SUB, CMD_SBC: begin
        s  = {1'b0, a} + {1'b0, ~b} + 33'((cmd == CMD_SUB) || c);
        r  = s[31:0];
        cf = s[32];
        vf = (a[31] != b[31]) && (r[31] != a[31]);
      end
      CMD_AND: r = a & b;
      CMD_ORR: r = a | b;
      CMD_EOR: r = a ^ b;
      CMD_MUL: r = a * b;
      default: r = '0;
    endcase
    e.out = r;
    e.sr  = {r == 32'd0, cf, r[31], vf};
    return e;
  endfunction

  task automatic drive(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic v);
    bus.alu_cmd  = cmd;
    bus.val1     = a;
    bus.val2     = b;
    bus.c_in     = c;
    bus.v_in     = v;
    bus.in_valid = 1'b1;
  endtask

  // Counts falling edges until out_valid; notes any in_ready while waiting.
  task automatic wait_valid(output int n, output bit rdy_seen);
    n = 0;
    rdy_seen = 1'b0;
    do begin
      @(negedge clk);
      n++;
      bus.in_valid = 1'b0;
      if (!bus.out_valid && bus.in_ready) rdy_seen = 1'b1;
    end while (!bus.out_valid && n < 100);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    total++; if (bus.alu_out !== 32'd0) begin bad++; $display("FAIL reset_alu_out: got %h want 0", bus.alu_out); end
    total++; if (bus.sr !== 4'b0000) begin bad++; $display("FAIL reset_sr: got %b want 0000", bus.sr); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    vec_t t[10];
    int n;
    bit rs;
    exp_t e;
    t[0] = '{"add_ovf",  CMD_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h80000000, 4'b0011};
    t[1] = '{"sub_zero", CMD_SUB, 32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 4'b1100};
    t[2] = '{"sbc_c1",   CMD_SBC, 32'h00000003, 32'h00000005, 1'b1, 1'b0, 32'hFFFFFFFE, 4'b0010};
    t[3] = '{"sbc_c0",   CMD_SBC, 32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'hFFFFFFFD, 4'b0010};
    t[4] = '{"sub_vneg", CMD_SUB, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 32'h7FFFFFFF, 4'b0101};
    t[5] = '{"adc_wrap", CMD_ADC, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 4'b1100};
    t[6] = '{"mvn",      CMD_MVN, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 4'b0111};
    t[7] = '{"and",      CMD_AND, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0, 1'b1, 32'h00000000, 4'b1001};
    t[8] = '{"eor",      CMD_EOR, 32'h12345678, 32'h80000000, 1'b1, 1'b0, 32'h92345678, 4'b0110};
    t[9] = '{"unknown",  4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 4'b1101};
    foreach (t[i]) begin
      drive(t[i].cmd, t[i].a, t[i].b, t[i].c, t[i].v);
      sb.push_back('{t[i].out, t[i].sr});
      wait_valid(n, rs);
      e = sb.pop_front();
      total++; if (n != 1) begin bad++; $display("FAIL %s_latency: got %0d want 1", t[i].name, n); end
      total++; if (bus.alu_out !== e.out) begin bad++; $display("FAIL %s_out: got %h want %h", t[i].name, bus.alu_out, e.out); end
      total++; if (bus.sr !== e.sr) begin bad++; $display("FAIL %s_sr: got %b want %b", t[i].name, bus.sr, e.sr); end
    end
  endtask

  task automatic test_mul();
    vec_t t[3];
    int n;
    bit rs;
    exp_t e;
    t[0] = '{"mul_plan", CMD_MUL, 32'h0000FFFF, 32'h00010001, 1'b1, 1'b0, 32'hFFFFFFFF, 4'b0110};
    t[1] = '{"mul_ones", CMD_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000001, 4'b0001};
    t[2] = '{"mul_zero", CMD_MUL, 32'h12345678, 32'h00000000, 1'b1, 1'b1, 32'h00000000, 4'b1101};
    foreach (t[i]) begin
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_at_issue: got %b want 1", t[i].name, bus.in_ready); end
      drive(t[i].cmd, t[i].a, t[i].b, t[i].c, t[i].v);
      sb.push_back('{t[i].out, t[i].sr});
      wait_valid(n, rs);
      e = sb.pop_front();
      total++; if (n != 33) begin bad++; $display("FAIL %s_latency: got %0d want 33", t[i].name, n); end
      total++; if (rs !== 1'b0) begin bad++; $display("FAIL %s_busy_ready: got %b want 0", t[i].name, rs); end
      total++; if (bus.alu_out !== e.out) begin bad++; $display("FAIL %s_out: got %h want %h", t[i].name, bus.alu_out, e.out); end
      total++; if (bus.sr !== e.sr) begin bad++; $display("FAIL %s_sr: got %b want %b", t[i].name, bus.sr, e.sr); end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    drive(CMD_ORR, 32'hF0F00000, 32'h00000F0F, 1'b0, 1'b1);
    sb.push_back('{32'hF0F00F0F, 4'b0011});
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL orr_valid: got %b want 1", bus.out_valid); end
    e = sb.pop_front();
    drive(CMD_ADD, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++; if (bus.alu_out !== e.out) begin bad++; $display("FAIL hold%0d_out: got %h want %h", k, bus.alu_out, e.out); end
      total++; if (bus.sr !== e.sr) begin bad++; $display("FAIL hold%0d_sr: got %b want %b", k, bus.sr, e.sr); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL hold%0d_in_ready: got %b want 0", k, bus.in_ready); end
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL hold%0d_valid: got %b want 1", k, bus.out_valid); end
    end
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
    sb.push_back('{32'h00000000, 4'b1101});
    @(negedge clk);
    bus.in_valid = 1'b0;
    e = sb.pop_front();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_add_valid: got %b want 1", bus.out_valid); end
    total++; if (bus.alu_out !== e.out) begin bad++; $display("FAIL bp_add_out: got %h want %h", bus.alu_out, e.out); end
    total++; if (bus.sr !== e.sr) begin bad++; $display("FAIL bp_add_sr: got %b want %b", bus.sr, e.sr); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[9];
    logic [3:0] cmd;
    logic [31:0] a, b;
    logic c, v;
    exp_t e;
    ops = '{CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC, CMD_AND, CMD_ORR, CMD_EOR};
    for (int j = 0; j <= 12; j++) begin
      if (j < 12) begin
        cmd = ops[$urandom_range(0, 8)];
        a = $urandom(); b = $urandom();
        c = 1'($urandom_range(0, 1)); v = 1'($urandom_range(0, 1));
        drive(cmd, a, b, c, v);
        sb.push_back(model(cmd, a, b, c, v));
      end else begin
        bus.in_valid = 1'b0;
      end
      if (j > 0) begin
        e = sb.pop_front();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b%0d_valid: got %b want 1", j, bus.out_valid); end
        total++; if (bus.alu_out !== e.out) begin bad++; $display("FAIL b2b%0d_out: got %h want %h", j, bus.alu_out, e.out); end
        total++; if (bus.sr !== e.sr) begin bad++; $display("FAIL b2b%0d_sr: got %b want %b", j, bus.sr, e.sr); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    bit rs;
    bit seen;
    exp_t e;
    drive(CMD_MUL, 32'h0000FFFF, 32'h00010001, 1'b1, 1'b0);
    repeat (10) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready: got %b want 1", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_result: got %b want 0", seen); end
    drive(CMD_MOV, 32'h0, 32'h12345678, 1'b1, 1'b1);
    sb.push_back('{32'h12345678, 4'b0101});
    wait_valid(n, rs);
    e = sb.pop_front();
    total++; if (n != 1) begin bad++; $display("FAIL mov_latency: got %0d want 1", n); end
    total++; if (bus.alu_out !== e.out) begin bad++; $display("FAIL mov_out: got %h want %h", bus.alu_out, e.out); end
    total++; if (bus.sr !== e.sr) begin bad++; $display("FAIL mov_sr: got %b want %b", bus.sr, e.sr); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.alu_cmd   = 4'b0000;
    bus.val1      = '0;
    bus.val2      = '0;
    bus.c_in      = 1'b0;
    bus.v_in      = 1'b0;
    test_reset();
    test_single();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle datapath ALU. It executes the existing 4-bit command set plus an iterative multiply (MUL). Results and the {Z,C,N,V} status are registered, so the EXE stage can stall on a multi-cycle multiply without extra glue. Sits between the ID/EXE pipeline register and the EXE/MEM register; one operation in flight.

## Interface
- WIDTH, 32: operand/result width (≥ 8).
- MUL_EN, 1: 1 = MUL implemented; 0 = MUL treated as unknown command.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  command/operands valid.
- in_ready  out  1  block can accept this cycle.
- alu_cmd  in  4  command: MOV 0001, MVN 1001, ADD/LDR/STR 0010, ADC 0011, SUB/CMP 0100, SBC 0101, AND/TST 0110, ORR 0111, EOR 1000, MUL 1010.
- val1, val2  in  WIDTH  operands (val1 = Rn, val2 = shifted operand).
- c_in, v_in  in  1  current C and V flags.
- out_valid  out  1  result/status valid.
- out_ready  in  1  consumer accepts result.
- alu_out  out  WIDTH  result.
- sr  out  4  {Z,C,N,V}.

## Operation
- FSM states: IDLE, MUL_BUSY, DONE.
  - IDLE: on in_valid accept, go to DONE for single-cycle ops, or to MUL_BUSY for MUL (MUL_EN=1).
  - MUL_BUSY: count WIDTH iterations, then go to DONE.
  - DONE: hold out_valid=1. On out_ready, return to IDLE, or accept a new command in the same cycle.
- in_ready = (state==IDLE) | (state==DONE & out_ready). A transfer occurs when in_valid & in_ready.
- Arithmetic is unsigned on a WIDTH+1-bit sum. C is the carry-out bit WIDTH.
  - SUB/SBC: computed as val1 + ~val2 + cin, with cin = 1 (SUB) or c_in (SBC). C = NOT borrow, ARM convention.
  - ADD/ADC: V = ~(a[msb]^b[msb]) & (r[msb]^a[msb]).
  - SUB/SBC: V = (a[msb]^b[msb]) & (r[msb]^a[msb]).
- N = alu_out[WIDTH-1]; Z = (alu_out == 0), for every command.
- MOV, MVN, AND, ORR, EOR, MUL: C = c_in, V = v_in (preserved).
- MUL: low WIDTH bits of val1*val2, computed by shift-add, one multiplier bit per cycle. Fixed WIDTH iterations; no early termination.
- Unknown command: alu_out = 0, Z=1, N=0, C=c_in, V=v_in. Takes the single-cycle path.
- Outputs are stable while out_valid & ~out_ready.
- Operands are captured at acceptance; input changes during MUL_BUSY are ignored.

## Timing
- Reset (async assert, synchronous deassert handled upstream): state=IDLE, out_valid=0, alu_out=0, sr=4'b0000, in_ready=1, multiplier counter=0.
- Reset asserted during MUL_BUSY or DONE aborts the operation immediately; no result is produced.
- Single-cycle op accepted at edge k: out_valid=1 after edge k+1.
- MUL accepted at edge k: out_valid=1 after edge k+WIDTH+1.
- Back-to-back throughput: one single-cycle op per clock while out_ready=1.
- in_ready is combinational from state and out_ready. No combinational path from in_valid or operands to any output.
- The iteration counter is $clog2(WIDTH)+1 bits and saturates; it never wraps.

## Structure
- Package alu_pkg holds:
  - command localparams (including MUL=4'b1010);
  - SR bit indices (SR_Z=3, SR_C=2, SR_N=1, SR_V=0);
  - FSM state enum.
- Sub-module alu_seq_mul (WIDTH): iterative shift-add multiplier with start/done.
  - Instantiated only when MUL_EN=1 (generate).
  - The top holds the FSM, single-cycle datapath and flag logic.

## Test plan
- ADD 0x7FFFFFFF + 0x00000001 -> alu_out 0x80000000, sr {Z0,C0,N1,V1}, out_valid one cycle after accept.
- SUB 5 - 5 -> alu_out 0, sr {1,1,0,0}.
- SBC 3 - 5 with c_in=1 -> 0xFFFFFFFE, sr {0,0,1,0}.
- SBC 3 - 5 with c_in=0 -> 0xFFFFFFFD, sr {0,0,1,0}.
- MUL 0x0000FFFF × 0x00010001, c_in=1, v_in=0 -> 0xFFFFFFFF, sr {0,1,1,0}. out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- Backpressure: ORR result held with out_ready=0 for 5 cycles -> alu_out/sr stable, in_ready=0. Raising out_ready with a new ADD pending -> ADD accepted that same cycle.
- rst_n pulled low at cycle 10 of a MUL -> out_valid=0 and in_ready=1 immediately. A subsequent MOV 0x12345678 -> 0x12345678, sr {0,c_in,0,v_in}.
